// File: rtl/timer_bank.sv
// timer_bank: bank of BCD HH:MM:SS timers sharing a 1 Hz tick and one command/edit bus.
// Each channel counts down to zero or up to its preset, with optional auto-reload.
module timer_bank #(
    parameter int NUM_CH    = 2,
    parameter int HR_DIGITS = 2,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                tick,
    input  logic [CH_W-1:0]                     sel,
    input  logic [2:0]                          digit_i,
    input  logic                                inc,
    input  logic                                start,
    input  logic                                stop,
    input  logic                                load,
    input  logic [NUM_CH-1:0]                   mode_up,
    input  logic [NUM_CH-1:0]                   auto_reload,
    output logic [NUM_CH*(16+4*HR_DIGITS)-1:0]  tm_o,
    output logic [NUM_CH-1:0]                   running_o,
    output logic [NUM_CH-1:0]                   done_o,
    output logic [NUM_CH-1:0]                   expired_o
);
    localparam int D = 4 + HR_DIGITS;
    localparam int W = 4 * D;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    function automatic logic [3:0] dig_max(input int i);
        return (i == 1 || i == 3) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
        logic [W-1:0] r;
        logic         cy;
        logic [3:0]   d;
        r  = v;
        cy = 1'b1;
        for (int i = 0; i < D; i++) begin
            d = v[4*i +: 4];
            if (cy) begin
                r[4*i +: 4] = up ? ((d == dig_max(i)) ? 4'd0 : d + 4'd1)
                                 : ((d == 4'd0) ? dig_max(i) : d - 4'd1);
                cy = up ? (d == dig_max(i)) : (d == 4'd0);
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_bump(input logic [W-1:0] v, input logic [2:0] k);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < D; i++)
            if (3'(i) == k)
                r[4*i +: 4] = (v[4*i +: 4] == dig_max(i)) ? 4'd0 : v[4*i +: 4] + 4'd1;
        return r;
    endfunction

    logic dig_ok;
    assign dig_ok = int'(digit_i) < D;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t       st_q, st_d;
        logic [W-1:0] cnt_q, cnt_d, pre_q, pre_d, nxt, bumped;
        logic         md_q, md_d, rl_q, rl_d, exp_q, exp_d, hit, em, term;

        assign hit    = sel == CH_W'(c);
        // latched direction only governs a channel that is mid-run
        assign em     = (st_q == RUN || st_q == PAUSE) ? md_q : mode_up[c];
        assign nxt    = bcd_step(cnt_q, md_q);
        assign term   = md_q ? (nxt == pre_q) : (nxt == '0);
        assign bumped = bcd_bump(pre_q, digit_i);

        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            pre_d = pre_q;
            md_d  = md_q;
            rl_d  = rl_q;
            exp_d = 1'b0;
            if (hit && load) begin
                if (st_q != RUN) begin
                    cnt_d = em ? '0 : pre_q;
                    st_d  = IDLE;
                end
            end else if (hit && stop) begin
                st_d = (st_q == RUN) ? PAUSE : st_q;
            end else if (hit && start) begin
                if (st_q == PAUSE || st_q == DONE || (st_q == IDLE && pre_q != '0)) begin
                    st_d  = RUN;
                    md_d  = mode_up[c];
                    rl_d  = auto_reload[c];
                    cnt_d = (st_q == DONE) ? (mode_up[c] ? '0 : pre_q) : cnt_q;
                end
            end else if (tick) begin
                if (st_q == RUN) begin
                    exp_d = term;
                    cnt_d = (term && rl_q) ? (md_q ? '0 : pre_q) : nxt;
                    st_d  = (term && !rl_q) ? DONE : RUN;
                end
            end else if (hit && inc && st_q == IDLE && dig_ok) begin
                pre_d = bumped;
                cnt_d = mode_up[c] ? '0 : bumped;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st_q  <= IDLE;
                cnt_q <= '0;
                pre_q <= '0;
                md_q  <= 1'b0;
                rl_q  <= 1'b0;
                exp_q <= 1'b0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                pre_q <= pre_d;
                md_q  <= md_d;
                rl_q  <= rl_d;
                exp_q <= exp_d;
            end
        end

        assign tm_o[c*W +: W] = cnt_q;
        assign running_o[c]   = st_q == RUN;
        assign done_o[c]      = st_q == DONE;
        assign expired_o[c]   = exp_q;
    end
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed and random checks of timer_bank against a seconds-based model.
module tb_timer_bank;
    localparam int NC = 2;
    localparam int D  = 6;
    localparam int W  = 24;
    localparam int M  = 360000;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic          clk = 1'b0, reset = 1'b1, tick = 1'b0, inc = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0;
    logic          sel = 1'b0;
    logic [2:0]    digit_i = 3'd0;
    logic [NC-1:0] mode_up = '0, auto_reload = '0;
    logic [NC*W-1:0] tm_o;
    logic [NC-1:0] running_o, done_o, expired_o;

    logic          tick1 = 1'b0, inc1 = 1'b0, start1 = 1'b0;
    logic [2:0]    dig1 = 3'd4;
    logic [19:0]   tm1;
    logic          run1, done1, exp1;

    int total = 0, bad = 0;
    bit chk_en = 1'b0;
    int cnt [NC];
    int pre [NC];
    int st  [NC];
    bit md  [NC];
    bit rl  [NC];
    bit ex  [NC];
    logic [NC*W-1:0] etm;
    logic [NC-1:0]   er, ed, ee;

    timer_bank #(.NUM_CH(NC), .HR_DIGITS(2)) dut (
        .clk(clk), .reset(reset), .tick(tick), .sel(sel), .digit_i(digit_i), .inc(inc),
        .start(start), .stop(stop), .load(load), .mode_up(mode_up), .auto_reload(auto_reload),
        .tm_o(tm_o), .running_o(running_o), .done_o(done_o), .expired_o(expired_o)
    );

    timer_bank #(.NUM_CH(1), .HR_DIGITS(1)) dut1 (
        .clk(clk), .reset(reset), .tick(tick1), .sel(1'b0), .digit_i(dig1), .inc(inc1),
        .start(start1), .stop(1'b0), .load(1'b0), .mode_up(1'b0), .auto_reload(1'b0),
        .tm_o(tm1), .running_o(run1), .done_o(done1), .expired_o(exp1)
    );

    always #5 clk = ~clk;

    function automatic int bcd2s(input logic [23:0] b);
        return b[3:0] + 10*b[7:4] + 60*b[11:8] + 600*b[15:12] + 3600*(b[19:16] + 10*b[23:20]);
    endfunction

    function automatic logic [23:0] s2bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h/10), 4'(h%10), 4'(m/10), 4'(m%10), 4'(x/10), 4'(x%10)};
    endfunction

    function automatic int bump(input int s, input int k);
        logic [23:0] b;
        int v, m;
        b = s2bcd(s);
        v = int'(b[4*k +: 4]);
        m = (k == 1 || k == 3) ? 6 : 10;
        b[4*k +: 4] = 4'((v + 1) % m);
        return bcd2s(b);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NC; c++) begin
            cnt[c] = 0; pre[c] = 0; st[c] = S_IDLE; md[c] = 0; rl[c] = 0; ex[c] = 0;
        end
    endtask

    task automatic model_step();
        bit h, em;
        int n;
        if (reset) begin
            model_clear();
            return;
        end
        for (int c = 0; c < NC; c++) begin
            ex[c] = 0;
            h  = (int'(sel) == c);
            em = (st[c] == S_RUN || st[c] == S_PAUSE) ? md[c] : mode_up[c];
            if (h && load) begin
                if (st[c] != S_RUN) begin
                    cnt[c] = em ? 0 : pre[c];
                    st[c]  = S_IDLE;
                end
            end else if (h && stop) begin
                if (st[c] == S_RUN) st[c] = S_PAUSE;
            end else if (h && start) begin
                if (st[c] == S_PAUSE || st[c] == S_DONE || (st[c] == S_IDLE && pre[c] != 0)) begin
                    if (st[c] == S_DONE) cnt[c] = mode_up[c] ? 0 : pre[c];
                    st[c] = S_RUN;
                    md[c] = mode_up[c];
                    rl[c] = auto_reload[c];
                end
            end else if (tick) begin
                if (st[c] == S_RUN) begin
                    n = md[c] ? (cnt[c] + 1) % M : (cnt[c] + M - 1) % M;
                    if (n == (md[c] ? pre[c] : 0)) begin
                        ex[c] = 1;
                        if (rl[c]) n = md[c] ? 0 : pre[c];
                        else st[c] = S_DONE;
                    end
                    cnt[c] = n;
                end
            end else if (h && inc && st[c] == S_IDLE && int'(digit_i) < D) begin
                pre[c] = bump(pre[c], int'(digit_i));
                cnt[c] = mode_up[c] ? 0 : pre[c];
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < NC; c++) begin
                etm[c*W +: W] = s2bcd(cnt[c]);
                er[c] = st[c] == S_RUN;
                ed[c] = st[c] == S_DONE;
                ee[c] = ex[c];
            end
            chk("model_tm", 64'(tm_o), 64'(etm));
            chk("model_run", 64'(running_o), 64'(er));
            chk("model_done", 64'(done_o), 64'(ed));
            chk("model_exp", 64'(expired_o), 64'(ee));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic press(input int d, input int n);
        digit_i = 3'(d);
        inc = 1'b1;
        repeat (n) cyc();
        inc = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_tm", 64'(tm_o), 64'd0);
        chk("rst_run", 64'(running_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_tm1", 64'(tm1), 64'd0);

        press(2, 1);
        press(0, 5);
        chk("edit_ch0", 64'(tm_o[23:0]), 64'h000105);
        chk("edit_ch1", 64'(tm_o[47:24]), 64'h0);
        press(1, 5);
        chk("edit_d1_5", 64'(tm_o[23:0]), 64'h000155);
        press(1, 1);
        chk("edit_d1_wrap", 64'(tm_o[23:0]), 64'h000105);

        pulse_start();
        chk("cd_running", 64'(running_o[0]), 64'd1);
        tick = 1'b1;
        repeat (64) cyc();
        chk("cd_64", 64'(tm_o[23:0]), 64'h000001);
        cyc();
        chk("cd_zero", 64'(tm_o[23:0]), 64'h0);
        chk("cd_exp", 64'(expired_o[0]), 64'd1);
        chk("cd_done", 64'(done_o[0]), 64'd1);
        chk("cd_notrun", 64'(running_o[0]), 64'd0);
        cyc();
        tick = 1'b0;
        chk("cd_hold", 64'(tm_o[23:0]), 64'h0);
        chk("cd_exp_once", 64'(expired_o[0]), 64'd0);

        load = 1'b1;
        cyc();
        load = 1'b0;
        chk("load_done", 64'(tm_o[23:0]), 64'h000105);
        press(0, 5);
        press(2, 9);
        press(4, 1);
        chk("borrow_pre", 64'(tm_o[23:0]), 64'h010000);
        pulse_start();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("borrow", 64'(tm_o[23:0]), 64'h005959);

        inc1 = 1'b1;
        cyc();
        inc1 = 1'b0;
        chk("hr1_pre", 64'(tm1), 64'h10000);
        start1 = 1'b1;
        cyc();
        start1 = 1'b0;
        tick1 = 1'b1;
        cyc();
        tick1 = 1'b0;
        chk("hr1_borrow", 64'(tm1), 64'h05959);

        sel = 1'b1;
        mode_up = 2'b10;
        auto_reload = 2'b10;
        press(0, 3);
        chk("up_cnt0", 64'(tm_o[47:24]), 64'h0);
        pulse_start();
        tick = 1'b1;
        repeat (2) cyc();
        chk("up_2", 64'(tm_o[47:24]), 64'h000002);
        cyc();
        chk("up_reload", 64'(tm_o[47:24]), 64'h0);
        chk("up_exp", 64'(expired_o[1]), 64'd1);
        chk("up_run", 64'(running_o[1]), 64'd1);
        repeat (3) cyc();
        tick = 1'b0;
        chk("up_exp2", 64'(expired_o[1]), 64'd1);
        chk("up_run2", 64'(running_o[1]), 64'd1);

        sel = 1'b0;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        load = 1'b1;
        cyc();
        load = 1'b0;
        press(4, 9);
        press(1, 1);
        press(0, 1);
        chk("prio_pre", 64'(tm_o[23:0]), 64'h000011);
        pulse_start();
        tick = 1'b1;
        cyc();
        chk("prio_10", 64'(tm_o[23:0]), 64'h000010);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        tick = 1'b0;
        chk("prio_stop_cnt", 64'(tm_o[23:0]), 64'h000010);
        chk("prio_stop_run", 64'(running_o[0]), 64'd0);
        start = 1'b1;
        load = 1'b1;
        cyc();
        start = 1'b0;
        load = 1'b0;
        chk("prio_load_cnt", 64'(tm_o[23:0]), 64'h000011);
        chk("prio_load_run", 64'(running_o[0]), 64'd0);

        #2 reset = 1'b1;
        model_clear();
        #1;
        chk("arst_tm", 64'(tm_o), 64'd0);
        chk("arst_run", 64'(running_o), 64'd0);
        chk("arst_done", 64'(done_o), 64'd0);
        chk("arst_exp", 64'(expired_o), 64'd0);
        cyc();
        reset = 1'b0;
        pulse_start();
        chk("start_pre0", 64'(running_o[0]), 64'd0);

        repeat (4000) begin
            sel = 1'($urandom_range(0, 1));
            digit_i = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
            inc   = ($urandom_range(0, 2) == 0);
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            load  = ($urandom_range(0, 19) == 0);
            tick  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 31) == 0) begin
                mode_up = 2'($urandom);
                auto_reload = 2'($urandom);
            end
            cyc();
        end
        {inc, start, stop, load, tick} = '0;
        cyc();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
